// File: rtl/fpro_bus_pkg.sv
// Shared FPro bus widths, master FSM state type and address-step helper.
package fpro_bus_pkg;

  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;
  localparam int SLOT_W      = 6;
  localparam int REG_W       = 5;

  // RD_CAP is only entered when FPRO_MST_RD_REG_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAP,
    RD_RSP
  } state_t;

  // Address for the next beat: held for FIFO-style registers, otherwise +1 wrapping at 2^21.
  function automatic logic [FPRO_ADDR_W-1:0] next_addr(input logic [FPRO_ADDR_W-1:0] a,
                                                       input logic                   fix);
    return fix ? a : a + FPRO_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fpro_bus_master.sv
// FPro MMIO bus initiator: command + write-data streams in, registered mmio
// strobes out, read data returned as a single-entry response stream.
// Build option: FPRO_MST_RD_REG_EN adds an RD_CAP state so read data is
// sampled one cycle after the strobe (slots with registered rd_data).
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready;
// valid may not depend on ready, and rsp_data/rsp_last hold while
// rsp_valid && !rsp_ready.
module fpro_bus_master
  import fpro_bus_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic                   cmd_fix,
  input  logic [FPRO_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   wd_valid,
  output logic                   wd_ready,
  input  logic [FPRO_DATA_W-1:0] wd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FPRO_DATA_W-1:0] rsp_data,
  output logic                   rsp_last,
  output logic                   busy,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [FPRO_ADDR_W-1:0] mmio_addr,
  output logic [FPRO_DATA_W-1:0] mmio_wr_data,
  input  logic [FPRO_DATA_W-1:0] mmio_rd_data,
  output state_t                 dbg_state
);

  state_t                 state_q, state_d;
  logic [FPRO_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   fix_q, fix_d;
  logic                   cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [FPRO_ADDR_W-1:0] maddr_q, maddr_d;
  logic [FPRO_DATA_W-1:0] mwdata_q, mwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [FPRO_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_last_q, rsp_last_d;

  // Next-state and registered-output decode; strobes default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    fix_d       = fix_q;
    cs_d        = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    cmd_ready   = 1'b0;
    wd_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          fix_d  = cmd_fix;
          if (cmd_wr) begin
            state_d = WRITE;
          end else begin
            // First read strobe is visible in the RD_ISSUE cycle.
            state_d = RD_ISSUE;
            cs_d    = 1'b1;
            rd_d    = 1'b1;
            maddr_d = cmd_addr;
          end
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        if (wd_valid) begin
          cs_d     = 1'b1;
          wr_d     = 1'b1;
          maddr_d  = addr_q;
          mwdata_d = wd_data;
          addr_d   = next_addr(addr_q, fix_q);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
`ifdef FPRO_MST_RD_REG_EN
        state_d = RD_CAP;
`else
        rsp_data_d  = mmio_rd_data;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == '0);
        state_d     = RD_RSP;
`endif
      end
`ifdef FPRO_MST_RD_REG_EN
      RD_CAP: begin
        rsp_data_d  = mmio_rd_data;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (cnt_q == '0);
        state_d     = RD_RSP;
      end
`endif
      RD_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr(addr_q, fix_q);
            cnt_d   = cnt_q - LEN_W'(1);
            cs_d    = 1'b1;
            rd_d    = 1'b1;
            maddr_d = next_addr(addr_q, fix_q);
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; asynchronous reset aborts any burst and drops strobes at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      fix_q       <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      maddr_q     <= '0;
      mwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      fix_q       <= fix_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = maddr_q;
  assign mmio_wr_data = mwdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_last     = rsp_last_q;
  assign dbg_state    = state_q;

endmodule
